// File: rtl/output_stream_decompressor.sv
// rtl/output_stream_decompressor.sv - rebuilds dense activation words from encoded/mask streams (option: DECOMP_ZERO_COUNT_EN)
module output_stream_decompressor #(
  parameter int MEM_BW     = 128,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clear,
  input  logic [MEM_BW-1:0] enc_data,
  input  logic              enc_valid,
  input  logic [MEM_BW-1:0] mask_data,
  input  logic              mask_valid,
  output logic [MEM_BW-1:0] dense_data,
  output logic              dense_valid,
  input  logic              dense_ready,
  output logic              overflow
`ifdef DECOMP_ZERO_COUNT_EN
  ,
  output logic [31:0]       zero_count
`endif
);

  localparam int N  = MEM_BW / DATA_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CW = $clog2(2 * N + 1);
  localparam int BW = 2 * MEM_BW;

  // ---------------- input FIFOs ----------------
  logic [MEM_BW-1:0] enc_mem  [FIFO_DEPTH];
  logic [MEM_BW-1:0] mask_mem [FIFO_DEPTH];
  logic [PW-1:0]     enc_wptr, enc_rptr, mask_wptr, mask_rptr;
  logic              enc_empty, enc_full, mask_empty, mask_full;
  logic              enc_pop, mask_pop, enc_wr, mask_wr;
  logic              enc_drop, mask_drop;
  logic [MEM_BW-1:0] enc_head, mask_head;

  assign enc_empty  = (enc_wptr == enc_rptr);
  assign enc_full   = (enc_wptr[AW] != enc_rptr[AW]) &&
                      (enc_wptr[AW-1:0] == enc_rptr[AW-1:0]);
  assign mask_empty = (mask_wptr == mask_rptr);
  assign mask_full  = (mask_wptr[AW] != mask_rptr[AW]) &&
                      (mask_wptr[AW-1:0] == mask_rptr[AW-1:0]);
  assign enc_head   = enc_mem[enc_rptr[AW-1:0]];
  assign mask_head  = mask_mem[mask_rptr[AW-1:0]];

  // A full FIFO still takes the word if an entry leaves in the same cycle
  assign enc_wr    = enc_valid  && (!enc_full  || enc_pop)  && !clear;
  assign mask_wr   = mask_valid && (!mask_full || mask_pop) && !clear;
  assign enc_drop  = enc_valid  && enc_full  && !enc_pop;
  assign mask_drop = mask_valid && mask_full && !mask_pop;

  // FIFO storage, no reset needed since pointers qualify every read
  always_ff @(posedge clk) begin
    if (enc_wr)  enc_mem[enc_wptr[AW-1:0]]   <= enc_data;
    if (mask_wr) mask_mem[mask_wptr[AW-1:0]] <= mask_data;
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      enc_wptr  <= '0;
      enc_rptr  <= '0;
      mask_wptr <= '0;
      mask_rptr <= '0;
    end else if (clear) begin
      enc_wptr  <= '0;
      enc_rptr  <= '0;
      mask_wptr <= '0;
      mask_rptr <= '0;
    end else begin
      if (enc_wr)   enc_wptr  <= enc_wptr + 1'b1;
      if (enc_pop)  enc_rptr  <= enc_rptr + 1'b1;
      if (mask_wr)  mask_wptr <= mask_wptr + 1'b1;
      if (mask_pop) mask_rptr <= mask_rptr + 1'b1;
    end
  end

  // ---------------- staging and expansion ----------------
  logic [BW-1:0]     stage, stage_shift, stage_next;
  logic [CW-1:0]     cnt, cnt_next, k, k_used;
  logic [SW-1:0]     slice_idx;
  logic [N-1:0]      slice;
  logic              out_free, emit, refill;
  logic [MEM_BW-1:0] dense_next;

  assign slice    = mask_head[slice_idx*N +: N];
  assign k        = CW'($countones(slice));
  assign out_free = !dense_valid || dense_ready;
  assign emit     = !mask_empty && (cnt >= k) && out_free;
  assign refill   = !enc_empty && (cnt <= CW'(N));
  assign k_used   = emit ? k : '0;
  assign enc_pop  = refill;
  assign mask_pop = emit && (slice_idx == SW'(DATA_W - 1));

  // Consume emitted elements, then append a fresh encoded word behind the survivors
  always_comb begin
    stage_shift = stage >> (int'(k_used) * DATA_W);
    stage_next  = stage_shift;
    cnt_next    = cnt - k_used;
    if (refill) begin
      stage_next = stage_shift |
                   ({{MEM_BW{1'b0}}, enc_head} << ((int'(cnt) - int'(k_used)) * DATA_W));
      cnt_next   = cnt - k_used + CW'(N);
    end
  end

  // Scatter staged elements into the mask-set lanes in ascending order
  always_comb begin
    int idx;
    idx        = 0;
    dense_next = '0;
    for (int i = 0; i < N; i++) begin
      if (slice[i]) begin
        dense_next[i*DATA_W +: DATA_W] = stage[idx*DATA_W +: DATA_W];
        idx = idx + 1;
      end
    end
  end

  // Staging buffer, slice counter and overflow flag
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stage     <= '0;
      cnt       <= '0;
      slice_idx <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      stage     <= '0;
      cnt       <= '0;
      slice_idx <= '0;
      overflow  <= 1'b0;
    end else begin
      stage <= stage_next;
      cnt   <= cnt_next;
      if (emit) begin
        slice_idx <= (slice_idx == SW'(DATA_W - 1)) ? '0 : slice_idx + 1'b1;
      end
      if (enc_drop || mask_drop) overflow <= 1'b1;
    end
  end

  // Output register: loads on emit, holds while the sink stalls
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dense_data  <= '0;
      dense_valid <= 1'b0;
    end else if (clear) begin
      dense_data  <= '0;
      dense_valid <= 1'b0;
    end else if (emit) begin
      dense_data  <= dense_next;
      dense_valid <= 1'b1;
    end else if (dense_ready) begin
      dense_valid <= 1'b0;
    end
  end

`ifdef DECOMP_ZERO_COUNT_EN
  logic [CW-1:0] out_zeros;
  logic [32:0]   zc_sum;

  assign zc_sum = {1'b0, zero_count} + 33'(out_zeros);

  // Zero-lane statistics, credited when the word actually leaves
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_zeros  <= '0;
      zero_count <= '0;
    end else if (clear) begin
      out_zeros  <= '0;
      zero_count <= '0;
    end else begin
      if (dense_valid && dense_ready) begin
        zero_count <= zc_sum[32] ? 32'hFFFF_FFFF : zc_sum[31:0];
      end
      if (emit) out_zeros <= CW'(N) - k;
    end
  end
`endif

endmodule

// File: tb/tb_output_stream_decompressor.sv
// tb/tb_output_stream_decompressor.sv - scoreboard bench for output_stream_decompressor
module tb_output_stream_decompressor;

  localparam int MEM_BW = 128;
  localparam int DATA_W = 8;
  localparam int FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              clear = 1'b0;
  logic [MEM_BW-1:0] enc_data = '0;
  logic              enc_valid = 1'b0;
  logic [MEM_BW-1:0] mask_data = '0;
  logic              mask_valid = 1'b0;
  logic [MEM_BW-1:0] dense_data;
  logic              dense_valid;
  logic              dense_ready = 1'b1;
  logic              overflow;
`ifdef DECOMP_ZERO_COUNT_EN
  logic [31:0]       zero_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [MEM_BW-1:0] exp_q[$];

  output_stream_decompressor #(
    .MEM_BW(MEM_BW), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .arst_n(arst_n), .clear(clear),
    .enc_data(enc_data), .enc_valid(enc_valid),
    .mask_data(mask_data), .mask_valid(mask_valid),
    .dense_data(dense_data), .dense_valid(dense_valid), .dense_ready(dense_ready),
    .overflow(overflow)
`ifdef DECOMP_ZERO_COUNT_EN
    , .zero_count(zero_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [MEM_BW-1:0] act, input logic [MEM_BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid and ready are both high here
  always @(negedge clk) begin
    if (arst_n && dense_valid && dense_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %h expected none", dense_data);
      end else begin
        check("dense_word", dense_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic logic [MEM_BW-1:0] ramp_word(input int base);
    logic [MEM_BW-1:0] w;
    for (int b = 0; b < 16; b++) w[b*8 +: 8] = 8'(base + b);
    return w;
  endfunction

  initial begin
    logic [MEM_BW-1:0] w;
    logic [MEM_BW-1:0] ones;
    ones = '1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", MEM_BW'(dense_valid), '0);
    check("rst_data", dense_data, '0);
    check("rst_overflow", MEM_BW'(overflow), '0);
    arst_n = 1'b1;
    tick();

    // All-ones mask, eight single-byte-pattern words, with latency check
    for (int j = 0; j < 8; j++) begin
      w = {16{8'(1 << j)}};
      exp_q.push_back(w);
      enc_data = w;
      enc_valid = 1'b1;
      mask_data = ones;
      mask_valid = (j == 0);
      tick();
      if (j == 1) check("latency_e1", MEM_BW'(dense_valid), '0);
      if (j == 2) check("latency_e2", MEM_BW'(dense_valid), 1);
    end
    enc_valid = 1'b0;
    mask_valid = 1'b0;
    wait_drain();

    // All-zeros mask, no encoded data: eight zero words on consecutive cycles
    for (int j = 0; j < 8; j++) exp_q.push_back('0);
    mask_data = '0;
    mask_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("zero_stream_valid", MEM_BW'(dense_valid), 1);
    end
    tick();
    check("zero_stream_end", MEM_BW'(dense_valid), '0);
    wait_drain();

    // Sparse slices crossing into the next slice
    exp_q.push_back(128'h00BB_00AA);
    exp_q.push_back({8'hCC, 120'h0});
    for (int j = 0; j < 6; j++) exp_q.push_back('0);
    mask_data = 128'h8000_0005;
    enc_data = 128'hCC_BBAA;
    mask_valid = 1'b1;
    enc_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    enc_valid = 1'b0;
    wait_drain();
    do_clear();

    // Backpressure: output must hold for 20 stalled cycles
    dense_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      w = ramp_word(j * 16);
      exp_q.push_back(w);
      enc_data = w;
      enc_valid = 1'b1;
      mask_data = ones;
      mask_valid = (j == 0);
      tick();
    end
    enc_valid = 1'b0;
    mask_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("stall_valid", MEM_BW'(dense_valid), 1);
      check("stall_data", dense_data, ramp_word(0));
    end
    check("stall_no_overflow", MEM_BW'(overflow), '0);
    dense_ready = 1'b1;
    wait_drain();
    do_clear();

    // Mask FIFO overflow, then clear beating a same-cycle write
    dense_ready = 1'b0;
    mask_data = ones;
    for (int j = 0; j < FIFO_DEPTH + 1; j++) begin
      mask_valid = 1'b1;
      tick();
      if (j == FIFO_DEPTH - 1) check("ovf_before", MEM_BW'(overflow), '0);
    end
    mask_valid = 1'b0;
    check("ovf_set", MEM_BW'(overflow), 1);
    clear = 1'b1;
    mask_data = '0;
    mask_valid = 1'b1;
    tick();
    clear = 1'b0;
    mask_valid = 1'b0;
    check("clear_ovf", MEM_BW'(overflow), '0);
    dense_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("clear_empty", MEM_BW'(dense_valid), '0);
    end

    // Asynchronous reset with five elements left in staging
    dense_ready = 1'b0;
    mask_data = {{112{1'b1}}, 16'h07FF};
    enc_data = ramp_word(8'h40);
    mask_valid = 1'b1;
    enc_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    enc_valid = 1'b0;
    repeat (4) tick();
    check("pre_rst_valid", MEM_BW'(dense_valid), 1);
    check("pre_rst_data", dense_data, 128'h4A49_4847_4645_4443_4241_40);
    @(posedge clk);
    #3;
    arst_n = 1'b0;
    #1;
    check("async_rst_valid", MEM_BW'(dense_valid), '0);
    check("async_rst_data", dense_data, '0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    dense_ready = 1'b1;
    tick();
    exp_q.push_back(128'h2211);
    for (int j = 0; j < 7; j++) exp_q.push_back('0);
    mask_data = 128'h3;
    enc_data = 128'h2211;
    mask_valid = 1'b1;
    enc_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    enc_valid = 1'b0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
